// File: rtl/c64_keys_to_amiga_rawkey.sv
// ---------------------------------------------------------------------------
// c64_keys_to_amiga_rawkey
//
// Turns the C64 keyboard matrix snapshot (plus RESTORE) coming from the
// Chameleon I/O block into Amiga rawkey make/break codes for the Minimig
// keyboard path.
//
// Processing chain:
//   1. A divider on ena_1mhz sets the matrix sample rate.
//   2. A key counts as stable once two consecutive samples agree.
//   3. A scan walks all 65 keys, one per clk. It compares the stable
//      state with what has already been reported.
//   4. Each change goes into a small code FIFO.
//
// Ports:
//   clk            system clock (sysclk)
//   reset          synchronous, active-high reset
//   ena_1mhz       one-clk-wide 1 MHz enable pulse
//   keys[63:0]     C64 matrix, index = row*8+col, 0 = pressed
//   restore_key_n  RESTORE key, 0 = pressed, handled as key index 64
//   code[7:0]      FIFO head: bit7 1 = break / 0 = make, bits6:0 rawkey
//   code_valid     FIFO non-empty
//   code_ack       pops the head on a clk edge while code_valid = 1
//   overflow_seen  sticky: a change had to wait because the FIFO was full
// ---------------------------------------------------------------------------
module c64_keys_to_amiga_rawkey #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena_1mhz,
  input  logic [63:0] keys,
  input  logic        restore_key_n,
  output logic [7:0]  code,
  output logic        code_valid,
  input  logic        code_ack,
  output logic        overflow_seen
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [6:0] LAST_IDX = 7'd64;
  localparam logic [6:0] UNMAPPED = 7'h7F;

  typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

  // C64 matrix position -> Amiga rawkey. Keys with no sensible Amiga
  // counterpart map to 7'h7F and are never emitted.
  function automatic logic [6:0] keymap(input logic [6:0] idx);
    case (idx)
      7'd0:  keymap = 7'h41; 7'd1:  keymap = 7'h44; 7'd2:  keymap = 7'h4E; 7'd3:  keymap = 7'h56;
      7'd4:  keymap = 7'h50; 7'd5:  keymap = 7'h52; 7'd6:  keymap = 7'h54; 7'd7:  keymap = 7'h4D;
      7'd8:  keymap = 7'h03; 7'd9:  keymap = 7'h11; 7'd10: keymap = 7'h20; 7'd11: keymap = 7'h04;
      7'd12: keymap = 7'h31; 7'd13: keymap = 7'h21; 7'd14: keymap = 7'h12; 7'd15: keymap = 7'h60;
      7'd16: keymap = 7'h05; 7'd17: keymap = 7'h13; 7'd18: keymap = 7'h22; 7'd19: keymap = 7'h06;
      7'd20: keymap = 7'h33; 7'd21: keymap = 7'h23; 7'd22: keymap = 7'h14; 7'd23: keymap = 7'h32;
      7'd24: keymap = 7'h07; 7'd25: keymap = 7'h15; 7'd26: keymap = 7'h24; 7'd27: keymap = 7'h08;
      7'd28: keymap = 7'h35; 7'd29: keymap = 7'h25; 7'd30: keymap = 7'h16; 7'd31: keymap = 7'h34;
      7'd32: keymap = 7'h09; 7'd33: keymap = 7'h17; 7'd34: keymap = 7'h26; 7'd35: keymap = 7'h0A;
      7'd36: keymap = 7'h37; 7'd37: keymap = 7'h27; 7'd38: keymap = 7'h18; 7'd39: keymap = 7'h36;
      7'd40: keymap = 7'h0C; 7'd41: keymap = 7'h19; 7'd42: keymap = 7'h28; 7'd43: keymap = 7'h0B;
      7'd44: keymap = 7'h39; 7'd45: keymap = 7'h29; 7'd46: keymap = 7'h1A; 7'd47: keymap = 7'h38;
      7'd48: keymap = 7'h0D; 7'd49: keymap = 7'h1B; 7'd50: keymap = 7'h2A; 7'd52: keymap = 7'h61;
      7'd55: keymap = 7'h3A; 7'd56: keymap = 7'h01; 7'd57: keymap = 7'h00; 7'd58: keymap = 7'h63;
      7'd59: keymap = 7'h02; 7'd60: keymap = 7'h40; 7'd61: keymap = 7'h66; 7'd62: keymap = 7'h10;
      7'd63: keymap = 7'h45; 7'd64: keymap = 7'h5F;
      default: keymap = UNMAPPED;  // HOME (51), '=' (53), up-arrow (54)
    endcase
  endfunction

  logic [15:0]   r_div;
  logic          w_sample_tick;
  logic [64:0]   w_raw;
  logic [64:0]   r_sample_prev;
  logic [64:0]   r_debounced;
  logic [64:0]   r_reported;
  logic          r_scan_req;
  scan_state_t   r_state;
  scan_state_t   w_state_nxt;
  logic [6:0]    r_idx;
  logic [6:0]    w_idx_nxt;
  logic          w_scan_start;
  logic [6:0]    w_rawkey;
  logic          w_mapped;
  logic          w_diff;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // ---------------- sample-rate divider ----------------
  assign w_sample_tick = ena_1mhz && (r_div == 16'(SCAN_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments. All registers
  // then update together at the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (reset)         r_div <= '0;
    else if (ena_1mhz) r_div <= w_sample_tick ? 16'd0 : r_div + 16'd1;
  end

  // ---------------- debounce ----------------
  assign w_raw = {restore_key_n, keys};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample_prev <= '1;
      r_debounced   <= '1;
      r_scan_req    <= 1'b0;
    end else begin
      if (w_sample_tick) begin
        r_sample_prev <= w_raw;
        if (w_raw == r_sample_prev) r_debounced <= w_raw;
      end
      // A new request wins over the clear. A sample that lands on the scan
      // start cycle therefore still gets its own scan.
      if (w_sample_tick && (w_raw == r_sample_prev)) r_scan_req <= 1'b1;
      else if (w_scan_start)                         r_scan_req <= 1'b0;
    end
  end

  // ---------------- scan FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // NOTE: every output of this block gets a default first. A path that
  // assigns nothing then keeps a defined value, so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_scan_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_scan_req) begin
          w_scan_start = 1'b1;
          w_state_nxt  = S_SCAN;
          w_idx_nxt    = '0;
        end
      end
      S_SCAN: begin
        if (r_idx == LAST_IDX) w_state_nxt = S_IDLE;
        else                   w_idx_nxt   = r_idx + 7'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- per-key change detection ----------------
  assign w_rawkey = keymap(r_idx);
  assign w_mapped = (w_rawkey != UNMAPPED);
  assign w_diff   = (r_state == S_SCAN) && (r_debounced[r_idx] != r_reported[r_idx]);
  // Fullness comes from the count at the start of the cycle. A pop in the
  // same cycle does not make room for this push.
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_push   = w_diff && w_mapped && !w_full;
  assign w_pop    = code_ack && code_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reported    <= '1;
      overflow_seen <= 1'b0;
    end else if (w_diff) begin
      // Unmapped keys are marked as reported without pushing. A mapped key
      // that meets a full FIFO stays pending until the next scan.
      if (!w_mapped || !w_full) r_reported[r_idx] <= r_debounced[r_idx];
      else                      overflow_seen     <= 1'b1;
    end
  end

  // ---------------- code FIFO ----------------
  // NOTE: the storage array is deliberately not reset. Only the count and
  // pointers decide which entries are live, and code is forced to 0 while
  // the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_debounced[r_idx], w_rawkey};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign code_valid = (r_count != '0);
  assign code       = code_valid ? r_mem[r_rd_ptr] : 8'h00;

endmodule

// File: tb/tb_c64_keys_to_amiga_rawkey.sv
// ---------------------------------------------------------------------------
// Self-checking bench for c64_keys_to_amiga_rawkey.
// SCAN_DIV = 4 and ena_1mhz pulses every 25 clk, so one sample period is
// 100 clk. A full 65-key scan therefore always finishes inside one period.
// Expected codes go into a queue when keys change. They are compared as the
// DUT presents them on code/code_valid.
// ---------------------------------------------------------------------------
module tb_c64_keys_to_amiga_rawkey;

  localparam int P = 100;  // clk per sample period

  logic        clk = 1'b0;
  logic        reset;
  logic        ena_1mhz;
  logic [63:0] keys;
  logic        restore_key_n;
  logic [7:0]  code;
  logic        code_valid;
  logic        code_ack;
  logic        overflow_seen;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  c64_keys_to_amiga_rawkey #(.SCAN_DIV(4), .FIFO_DEPTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .ena_1mhz      (ena_1mhz),
    .keys          (keys),
    .restore_key_n (restore_key_n),
    .code          (code),
    .code_valid    (code_valid),
    .code_ack      (code_ack),
    .overflow_seen (overflow_seen)
  );

  always #5 clk = ~clk;

  // Free-running 1 MHz enable, one clk wide every 25 clk.
  initial begin
    int cnt = 0;
    ena_1mhz = 1'b0;
    forever begin
      @(negedge clk);
      cnt++;
      ena_1mhz = (cnt % 25 == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for a code, compare it with the scoreboard head, then ack.
  task automatic pop_expect(input string tag, input int budget);
    int n = 0;
    logic [31:0] exp;
    while (!code_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD;
    if (!code_valid) begin
      check({tag, "_timeout"}, 32'(code_valid), 32'd1);
    end else begin
      check(tag, 32'(code), exp);
      code_ack = 1'b1;
      @(negedge clk);
      code_ack = 1'b0;
    end
  endtask

  // Ten mapped keys in ascending index order, with their rawkeys.
  int          grp_idx [10] = '{0, 1, 9, 10, 17, 33, 57, 60, 62, 63};
  logic [6:0]  grp_key [10] = '{7'h41, 7'h44, 7'h11, 7'h20, 7'h13,
                                7'h17, 7'h00, 7'h40, 7'h10, 7'h45};

  // Change all ten keys at once with ack held low. Eight codes fit and two
  // wait for a later scan.
  task automatic group_change(input logic level, input string tag);
    for (int i = 0; i < 10; i++) begin
      keys[grp_idx[i]] = level;
      exp_q.push_back({24'h0, level, grp_key[i]});
    end
    cycles(3 * P);
    check({tag, "_valid"}, 32'(code_valid), 32'd1);
    check({tag, "_ovf"},   32'(overflow_seen), 32'd1);
    for (int i = 0; i < 8; i++) pop_expect({tag, "_first8"}, 10);
    for (int i = 0; i < 2; i++) pop_expect({tag, "_last2"}, 2 * P + 70);
    cycles(2 * P);
    check({tag, "_no_dup"}, 32'(code_valid), 32'd0);
  endtask

  initial begin
    logic seen;
    reset         = 1'b1;
    keys          = '1;
    restore_key_n = 1'b1;
    code_ack      = 1'b0;
    cycles(3);
    check("rst_code",  32'(code), 32'h00);
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_ovf",   32'(overflow_seen), 32'd0);
    reset = 1'b0;

    // Idle: all released for 20 sample periods.
    seen = 1'b0;
    for (int i = 0; i < 20 * P; i++) begin
      @(negedge clk);
      if (code_valid) seen = 1'b1;
    end
    check("idle_valid", 32'(seen), 32'd0);
    check("idle_ovf",   32'(overflow_seen), 32'd0);

    // RETURN press then release. The 270-clk budget includes the
    // two-sample latency.
    keys[1] = 1'b0;
    exp_q.push_back(32'h44);
    pop_expect("ret_make", 2 * P + 70);
    cycles(P);
    keys[1] = 1'b1;
    exp_q.push_back(32'hC4);
    pop_expect("ret_break", 2 * P + 70);

    // SPACE glitch lasting exactly one sample period is sampled only once.
    cycles(P);
    keys[60] = 1'b0;
    cycles(P);
    keys[60] = 1'b1;
    cycles(3 * P);
    check("glitch_valid", 32'(code_valid), 32'd0);

    // Unmapped key (HOME) never produces a code.
    keys[51] = 1'b0;
    cycles(3 * P);
    check("unmapped_make", 32'(code_valid), 32'd0);
    keys[51] = 1'b1;
    cycles(3 * P);
    check("unmapped_break", 32'(code_valid), 32'd0);

    // Overflow with ten simultaneous changes, both directions.
    group_change(1'b0, "grp_make");
    group_change(1'b1, "grp_break");

    // RESTORE.
    restore_key_n = 1'b0;
    exp_q.push_back(32'h5F);
    pop_expect("restore_make", 2 * P + 70);
    restore_key_n = 1'b1;
    exp_q.push_back(32'hDF);
    pop_expect("restore_break", 2 * P + 70);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three queued entries while RUN/STOP is held.
    keys[0]  = 1'b0;
    keys[1]  = 1'b0;
    keys[63] = 1'b0;
    cycles(3 * P);
    check("pre_rst_valid", 32'(code_valid), 32'd1);
    reset   = 1'b1;
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(code_valid), 32'd0);
    check("mid_rst_code",  32'(code), 32'h00);
    check("mid_rst_ovf",   32'(overflow_seen), 32'd0);
    cycles(2);
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h45);
    pop_expect("post_rst_make", 3 * P + 70);
    cycles(2 * P);
    check("post_rst_once", 32'(code_valid), 32'd0);
    keys[63] = 1'b1;
    exp_q.push_back(32'hC5);
    pop_expect("post_rst_break", 3 * P + 70);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
